// File: rtl/cpu_ram_bank.sv
// Synchronous CPU work RAM with per-lane write masking, registered reads on a shared
// bidirectional bus, and a hardware sweep that fills the array with CLEAR_VALUE.
module cpu_ram_bank #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 8,
    parameter int                NIB_W          = 4,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                      CLK,
    input  logic                      RESET_AL,
    input  logic                      RAM_AL,
    input  logic                      MW_AL,
    input  logic                      MR_AL,
    input  logic [DATA_W/NIB_W-1:0]   NIB_WE_AL,
    input  logic                      CLR_REQ_AL,
    input  logic [ADDR_W-1:0]         A,
    inout  wire  [DATA_W-1:0]         D,
    output logic                      BUSY,
    output logic                      RD_VALID
);
    localparam int LANES = DATA_W / NIB_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0]   q_reg;
    logic                rd_valid_reg;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   merged_word;
    logic                bus_wr;
    logic                bus_drive;

    assign rd_word = mem[A];
    assign bus_wr  = (state_reg == ST_IDLE) && !RAM_AL && !MW_AL;

    // Lanes with an asserted enable take the bus; the rest keep the stored nibble.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign merged_word[gi*NIB_W +: NIB_W] = NIB_WE_AL[gi] ? rd_word[gi*NIB_W +: NIB_W]
                                                              : D[gi*NIB_W +: NIB_W];
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == '1) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            ST_IDLE: begin
                if (!CLR_REQ_AL)
                    state_next = ST_CLEAR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_AL) begin
        if (!RESET_AL) begin
            state_reg    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_reg      <= '0;
            q_reg        <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rd_valid_reg <= (state_reg == ST_IDLE) && !RAM_AL && MW_AL && !MR_AL;
            // Write-first: a same-edge write is reflected in the read register.
            if (state_reg == ST_IDLE)
                q_reg <= bus_wr ? merged_word : rd_word;
        end
    end

    // Array contents survive reset; writes are simply suppressed while it is held.
    always_ff @(posedge CLK) begin
        if (RESET_AL) begin
            if (state_reg == ST_CLEAR)
                mem[cnt_reg] <= CLEAR_VALUE;
            else if (bus_wr)
                mem[A] <= merged_word;
        end
    end

    assign bus_drive = (state_reg == ST_IDLE) && rd_valid_reg && !RAM_AL && !MR_AL && MW_AL;
    assign D         = bus_drive ? q_reg : 'z;
    assign BUSY      = (state_reg == ST_CLEAR);
    assign RD_VALID  = rd_valid_reg;
endmodule

// File: doc/cpu_ram_bank.md
# cpu_ram_bank

Parametrised synchronous replacement for the CPU board work RAM: a clocked 2^ADDR_W x DATA_W store built from NIB_W-wide lanes with individually maskable lane writes. It sits on the CPU board behind the address decoder, in the same place as the discrete 2114 RAM pair. It keeps the active-low RAM select / memory-write strobes and the shared bidirectional data bus. It adds registered reads, per-lane write masking and a hardware clear sequencer that zero-fills the array after reset or on request.

## Interface
- ADDR_W, 10, address width; depth = 2^ADDR_W words
- DATA_W, 8, data bus width; must be a multiple of NIB_W
- NIB_W, 4, lane width; LANES = DATA_W/NIB_W
- CLEAR_ON_RESET, 1, 1 = run clear sweep after reset release, 0 = come up IDLE
- CLEAR_VALUE, 0, DATA_W-bit word written by the clear sweep

- CLK  in  1  sole clock, all state on rising edge
- RESET_AL  in  1  asynchronous, active-low reset
- RAM_AL  in  1  RAM select, active low
- MW_AL  in  1  memory write strobe, active low
- MR_AL  in  1  memory read / bus drive enable, active low
- NIB_WE_AL  in  LANES  per-lane write enable, active low; lane i = D[i*NIB_W +: NIB_W]
- CLR_REQ_AL  in  1  synchronous clear request, active low, sampled each CLK
- A  in  ADDR_W  word address
- D  inout  DATA_W  shared CPU data bus
- BUSY  out  1  clear sweep in progress
- RD_VALID  out  1  registered read data on D corresponds to A from previous cycle

## Operation
- Clock and reset are fixed: a single clock, CLK; RESET_AL is asynchronous and active-low.
- FSM states: CLEAR, IDLE.
- Reset (RESET_AL=0): state = CLEAR if CLEAR_ON_RESET else IDLE, clear counter = 0, read register q = 0, RD_VALID = 0, D = high-Z. BUSY = 1 in reset only when CLEAR_ON_RESET=1. Array contents are not reset.
- CLEAR: each cycle write CLEAR_VALUE (all lanes) to mem[counter], then counter++. After writing address 2^ADDR_W-1, go to IDLE and set counter = 0. BUSY = 1 throughout CLEAR.
  - All bus writes are dropped and D is not driven.
  - CLR_REQ_AL is ignored; it does not restart the sweep.
- IDLE -> CLEAR when CLR_REQ_AL=0 on a rising edge. The sweep begins at address 0 on the next edge.
- Write (IDLE): on each rising edge with RAM_AL=0 and MW_AL=0, lane i of mem[A] takes D lane i for every i with NIB_WE_AL[i]=0. Masked lanes are unchanged. A level-held strobe rewrites every cycle; this is idempotent.
- Read register: in IDLE, q <= mem[A] every edge, write-first. If the same edge writes mem[A], q takes the post-write merged word.
- RD_VALID <= (IDLE and RAM_AL=0 and MW_AL=1 and MR_AL=0), registered.
- D driven with q when RD_VALID=1 and RAM_AL=0, MR_AL=0, MW_AL=1 are all currently true; otherwise high-Z. Write always wins over read: MW_AL=0 forces D high-Z.
- RAM_AL=1: no write, no drive; q keeps updating (don't-care).
- Simultaneous CLR_REQ_AL=0 and a write in IDLE: the write completes on that edge, then the sweep overwrites the array.
- Reset mid-sweep: counter returns to 0 and the sweep restarts from address 0 after release (CLEAR_ON_RESET=1), or the FSM goes IDLE with a partially cleared array (CLEAR_ON_RESET=0).

## Timing
- Write latency: data visible in mem at the edge where the strobe is sampled low.
- Read latency: 1 cycle. A stable at edge N gives q valid after edge N and D driven valid in cycle N+1 with RD_VALID=1.
- Clear sweep: exactly 2^ADDR_W cycles (1024 at default). BUSY falls on the edge that writes the last address. The first honoured bus access is sampled on the following edge.
- CLR_REQ_AL to BUSY=1: one edge.
- Counter is ADDR_W bits and wraps naturally. The terminal compare is on all-ones, not on overflow.

## Test plan
- Reset with CLEAR_ON_RESET=1, release: BUSY=1 for 1024 cycles, then 0. Reads of addresses 0x000, 0x1FF and 0x3FF return 0x00; D is high-Z throughout the sweep.
- IDLE, write 0xA5 to 0x123 with NIB_WE_AL=00, then write 0x3C with NIB_WE_AL=10: read of 0x123 returns 0xAC with RD_VALID=1 one cycle after A applied.
- Write 0x5A to 0x010 while MR_AL=0 in the same cycle: D stays high-Z during the write; the next read cycle returns 0x5A (write-first).
- In IDLE, pulse CLR_REQ_AL for one cycle; attempt a write of 0xFF to 0x005 mid-sweep: write dropped, and after BUSY falls 0x005 reads 0x00.
- Assert RESET_AL at sweep count 0x200: BUSY stays 1, the sweep restarts at 0 and takes a full 1024 cycles after release.
- CLEAR_ON_RESET=0, ADDR_W=4, DATA_W=16: BUSY=0 out of reset; lane-masked writes on all 4 lanes verified; a sweep via CLR_REQ_AL takes 16 cycles.
